// File: rtl/digit_select_ctrl.sv
// digit_select_ctrl: sequences residual passes and selects quotient digits.
// Optional sticky overflow flag: define DIGIT_SEL_OVF_DETECT_EN.
module digit_select_ctrl #(
  parameter int UNROLLING    = 64,
  parameter int ADDR_WIDTH   = 7,
  parameter int UPPER_WIDTH  = 5,
  parameter int NUM_CHUNKS   = 4,
  parameter int ONLINE_DELAY = 3,
  parameter int NUM_DIGITS   = 32
) (
  input  logic                   clk,
  input  logic                   asyn_reset_n,
  input  logic                   start,
  input  logic [UNROLLING-1:0]   w_plus_frac,
  input  logic [UNROLLING-1:0]   w_minus_frac,
  input  logic [UPPER_WIDTH-1:0] w_plus_int,
  input  logic [UPPER_WIDTH-1:0] w_minus_int,
  output logic                   w_enable,
  output logic                   refresh,
  output logic [ADDR_WIDTH-1:0]  rd_addr,
  output logic [ADDR_WIDTH-1:0]  wr_addr,
  output logic                   q_plus,
  output logic                   q_minus,
  output logic                   q_valid,
  input  logic                   q_ready,
  output logic                   busy,
  output logic                   done,
  output logic                   ovf
);

  localparam int EW = UPPER_WIDTH + 3;
  localparam int IW = $clog2(ONLINE_DELAY + 2);
  localparam int DW = $clog2(NUM_DIGITS + 1);
  localparam logic [ADDR_WIDTH-1:0] LAST = ADDR_WIDTH'(NUM_CHUNKS - 1);
  localparam logic [ADDR_WIDTH-1:0] ONE = ADDR_WIDTH'(1);
  localparam logic [IW-1:0] OD = IW'(ONLINE_DELAY);
  localparam logic [DW-1:0] ND_M1 = DW'(NUM_DIGITS - 1);
  localparam logic signed [EW-1:0] P_HALF = 2;
  localparam logic signed [EW-1:0] N_HALF = -2;

  typedef enum logic [2:0] {
    S_IDLE, S_LOAD, S_PASS, S_SELECT, S_OUT
  } state_e;

  state_e state_q, state_d;
  logic [ADDR_WIDTH-1:0] cnt_q, cnt_d;
  logic [IW-1:0] iter_q, iter_d;
  logic [DW-1:0] dig_q, dig_d;
  logic [UPPER_WIDTH-1:0] ip_q, ip_d;
  logic [UPPER_WIDTH-1:0] im_q, im_d;
  logic [1:0] fp_q, fp_d, fm_q, fm_d;
  logic qp_q, qp_d, qm_q, qm_d;
  logic done_q, done_d;

  logic signed [EW-1:0] ep, em, est;
  logic sel_pos, sel_neg;
  logic unused_frac;

  // Only the two top fraction bits feed the estimate.
  assign unused_frac = ^{w_plus_frac[UNROLLING-3:0],
                         w_minus_frac[UNROLLING-3:0]};

  // Residual estimate in quarter units, sign-extended operands.
  assign ep = {ip_q[UPPER_WIDTH-1], ip_q, fp_q};
  assign em = {im_q[UPPER_WIDTH-1], im_q, fm_q};
  assign est = ep - em;
  assign sel_pos = est >= P_HALF;
  assign sel_neg = est < N_HALF;

  // State, counters, latched estimate and digit registers.
  always_ff @(posedge clk or negedge asyn_reset_n) begin
    if (!asyn_reset_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      iter_q  <= '0;
      dig_q   <= '0;
      ip_q    <= '0;
      im_q    <= '0;
      fp_q    <= '0;
      fm_q    <= '0;
      qp_q    <= 1'b0;
      qm_q    <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      iter_q  <= iter_d;
      dig_q   <= dig_d;
      ip_q    <= ip_d;
      im_q    <= im_d;
      fp_q    <= fp_d;
      fm_q    <= fm_d;
      qp_q    <= qp_d;
      qm_q    <= qm_d;
      done_q  <= done_d;
    end
  end

  // Next-state logic: pass sequencing, digit selection, handshake.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    iter_d  = iter_q;
    dig_d   = dig_q;
    ip_d    = ip_q;
    im_d    = im_q;
    fp_d    = fp_q;
    fm_d    = fm_q;
    qp_d    = qp_q;
    qm_d    = qm_q;
    done_d  = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_LOAD;
          cnt_d   = '0;
          iter_d  = '0;
          dig_d   = '0;
        end
      end
      S_LOAD: state_d = S_PASS;
      S_PASS: begin
        if (cnt_q == ONE) begin
          ip_d = w_plus_int;
          im_d = w_minus_int;
          fp_d = w_plus_frac[UNROLLING-1 -: 2];
          fm_d = w_minus_frac[UNROLLING-1 -: 2];
        end
        if (cnt_q == LAST) begin
          cnt_d   = '0;
          state_d = S_SELECT;
        end else begin
          cnt_d = cnt_q + ONE;
        end
      end
      S_SELECT: begin
        if (iter_q < OD) begin
          iter_d  = iter_q + IW'(1);
          state_d = S_PASS;
        end else begin
          qp_d    = sel_pos;
          qm_d    = sel_neg;
          state_d = S_OUT;
        end
      end
      S_OUT: begin
        if (q_ready) begin
          dig_d = dig_q + DW'(1);
          if (dig_q == ND_M1) begin
            state_d = S_IDLE;
            done_d  = 1'b1;
          end else begin
            state_d = S_PASS;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign busy     = state_q != S_IDLE;
  assign w_enable = (state_q == S_LOAD) || (state_q == S_PASS);
  assign refresh  = state_q == S_LOAD;
  assign rd_addr  = (state_q == S_PASS) ? cnt_q : '0;
  assign wr_addr  = rd_addr;
  assign q_valid  = state_q == S_OUT;
  assign q_plus   = qp_q;
  assign q_minus  = qm_q;
  assign done     = done_q;

`ifdef DIGIT_SEL_OVF_DETECT_EN
  localparam logic signed [EW-1:0] P_TWO = 8;
  localparam logic signed [EW-1:0] N_TWO = -8;
  logic ovf_q, ovf_d;

  // Sticky flag for estimates beyond +/-2; cleared by a new load.
  always_comb begin
    ovf_d = ovf_q;
    if (state_q == S_LOAD) begin
      ovf_d = 1'b0;
    end else if (state_q == S_SELECT) begin
      if ((est > P_TWO) || (est < N_TWO)) begin
        ovf_d = 1'b1;
      end
    end
  end

  // Overflow flag register.
  always_ff @(posedge clk or negedge asyn_reset_n) begin
    if (!asyn_reset_n) begin
      ovf_q <= 1'b0;
    end else begin
      ovf_q <= ovf_d;
    end
  end

  assign ovf = ovf_q;
`else
  assign ovf = 1'b0;
`endif

endmodule

// File: tb/tb_digit_select_ctrl.sv
// tb_digit_select_ctrl: directed and randomized digit-selection checks.
// Expected digits come from a real-valued residual estimate model.
module tb_digit_select_ctrl;

  localparam int UNR = 64;
  localparam int AW  = 7;
  localparam int UW  = 5;
  localparam int NC  = 4;
  localparam int OD  = 3;
  localparam int ND  = 32;
`ifdef DIGIT_SEL_OVF_DETECT_EN
  localparam bit OVF_EN = 1'b1;
`else
  localparam bit OVF_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic asyn_reset_n;
  logic start;
  logic q_ready;
  logic [UNR-1:0] w_plus_frac, w_minus_frac;
  logic [UW-1:0] w_plus_int, w_minus_int;
  logic w_enable, refresh;
  logic [AW-1:0] rd_addr, wr_addr;
  logic q_plus, q_minus, q_valid;
  logic busy, done, ovf;

  logic [UNR-1:0] tfp [NC];
  logic [UNR-1:0] tfm [NC];
  logic [UW-1:0] tip [NC];
  logic [UW-1:0] tim [NC];

  int total = 0;
  int bad = 0;
  bit ovf_exp;

  always #5 clk = ~clk;

  digit_select_ctrl dut (
    .clk          (clk),
    .asyn_reset_n (asyn_reset_n),
    .start        (start),
    .w_plus_frac  (w_plus_frac),
    .w_minus_frac (w_minus_frac),
    .w_plus_int   (w_plus_int),
    .w_minus_int  (w_minus_int),
    .w_enable     (w_enable),
    .refresh      (refresh),
    .rd_addr      (rd_addr),
    .wr_addr      (wr_addr),
    .q_plus       (q_plus),
    .q_minus      (q_minus),
    .q_valid      (q_valid),
    .q_ready      (q_ready),
    .busy         (busy),
    .done         (done),
    .ovf          (ovf)
  );

  // Residual stage stand-in: returns the chunk at the read address.
  always_comb begin
    w_plus_frac  = '0;
    w_minus_frac = '0;
    w_plus_int   = '0;
    w_minus_int  = '0;
    if (rd_addr < AW'(NC)) begin
      w_plus_frac  = tfp[rd_addr[1:0]];
      w_minus_frac = tfm[rd_addr[1:0]];
      w_plus_int   = tip[rd_addr[1:0]];
      w_minus_int  = tim[rd_addr[1:0]];
    end
  end

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  // Residual value seen at chunk 1, as a real number.
  function automatic real est_val();
    int di, df;
    di = int'($signed(tip[1])) - int'($signed(tim[1]));
    df = int'(tfp[1][UNR-1 -: 2]) - int'(tfm[1][UNR-1 -: 2]);
    return real'(di) + real'(df) / 4.0;
  endfunction

  function automatic logic [1:0] exp_digit();
    real v;
    v = est_val();
    if (v >= 0.5) return 2'b10;
    if (v < -0.5) return 2'b01;
    return 2'b00;
  endfunction

  function automatic bit exp_big();
    real v;
    v = est_val();
    return (v > 2.0) || (v < -2.0);
  endfunction

  // mode 0: +1.0 held everywhere; 1: directed list; 2: random.
  task automatic set_tab(input int mode, input int idx);
    logic [1:0] fp, fm;
    for (int c = 0; c < NC; c++) begin
      tfp[c] = {$urandom, $urandom};
      tfm[c] = {$urandom, $urandom};
      tip[c] = UW'($urandom);
      tim[c] = UW'($urandom);
      if (mode == 0) begin
        tip[c] = 1;
        tim[c] = 0;
        tfp[c][UNR-1 -: 2] = 2'b00;
        tfm[c][UNR-1 -: 2] = 2'b00;
      end
    end
    if (mode == 1) begin
      tip[1] = 0;
      tim[1] = 0;
      fp = 2'b00;
      fm = 2'b00;
      case (idx % 5)
        0: fp = 2'b01;
        1: fm = 2'b10;
        2: fm = 2'b11;
        3: fp = 2'b10;
        default: tip[1] = 3;
      endcase
      tfp[1][UNR-1 -: 2] = fp;
      tfm[1][UNR-1 -: 2] = fm;
    end
  endtask

  task automatic run_op(input int mode, input int stall_max,
                        input bit hold_rdy, input bit poke,
                        input bit chain);
    int k;
    int stall;
    logic [1:0] d;
    set_tab(mode, 0);
    q_ready = hold_rdy;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("load_refresh", refresh, 1);
    chk("load_wen", w_enable, 1);
    chk("load_busy", busy, 1);
    ovf_exp = 1'b0;
    for (int i = 0; i <= OD; i++) ovf_exp |= exp_big();
    for (int n = 0; n < ND; n++) begin
      k = 0;
      while (!q_valid && k < 200) begin
        if (poke) start = (k == 2);
        @(negedge clk);
        k++;
      end
      start = 1'b0;
      chk(n == 0 ? "lat_first" : "lat_next", k, n == 0 ? 21 : 5);
      d = exp_digit();
      chk("digit", {q_plus, q_minus}, d);
      chk("ovf", ovf, OVF_EN ? ovf_exp : 1'b0);
      stall = hold_rdy ? 0 :
              (n == 5 ? 10 : $urandom_range(stall_max, 0));
      for (int s = 0; s < stall; s++) begin
        @(negedge clk);
        chk("stall_valid", q_valid, 1);
        chk("stall_digit", {q_plus, q_minus}, d);
        chk("stall_wen_addr", {w_enable, rd_addr, wr_addr}, 0);
      end
      if (n < ND - 1) begin
        set_tab(mode, n + 1);
        ovf_exp |= exp_big();
      end
      q_ready = 1'b1;
      @(negedge clk);
      if (!hold_rdy) q_ready = 1'b0;
    end
    chk("done", done, 1);
    chk("end_busy", busy, 0);
    chk("end_ovf", ovf, OVF_EN ? ovf_exp : 1'b0);
    if (!chain) begin
      @(negedge clk);
      chk("done_pulse", done, 0);
    end
  endtask

  initial begin
    int k;
    asyn_reset_n = 1'b0;
    start = 1'b0;
    q_ready = 1'b0;
    set_tab(2, 0);
    @(negedge clk);
    @(negedge clk);
    chk("reset_outs", {busy, w_enable, refresh, rd_addr, wr_addr,
        q_plus, q_minus, q_valid, done, ovf}, 0);
    asyn_reset_n = 1'b1;
    repeat (3) @(negedge clk);
    chk("idle_stays", {busy, w_enable, q_valid}, 0);

    run_op(0, 0, 1'b1, 1'b0, 1'b0);
    run_op(1, 3, 1'b0, 1'b1, 1'b1);
    run_op(2, 2, 1'b0, 1'b0, 1'b0);
    run_op(0, 1, 1'b0, 1'b1, 1'b0);

    q_ready = 1'b1;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    k = 0;
    while (rd_addr != AW'(2) && k < 50) begin
      @(negedge clk);
      k++;
    end
    chk("reach_cnt2", rd_addr, 2);
    #2 asyn_reset_n = 1'b0;
    #1;
    chk("rst_mid_pass", {busy, w_enable, refresh, rd_addr, wr_addr,
        q_plus, q_minus, q_valid, done, ovf}, 0);
    @(negedge clk);
    asyn_reset_n = 1'b1;
    repeat (2) @(negedge clk);
    chk("post_rst_idle", busy, 0);

    set_tab(0, 0);
    q_ready = 1'b0;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("restart_refresh", {refresh, w_enable, rd_addr}, {1'b1, 1'b1, 7'd0});
    k = 0;
    while (!q_valid && k < 100) begin
      @(negedge clk);
      k++;
    end
    chk("restart_lat", k, 21);
    repeat (3) @(negedge clk);
    chk("stall_before_rst", {q_valid, q_plus, q_minus}, 3'b110);
    #2 asyn_reset_n = 1'b0;
    #1;
    chk("rst_in_out", {busy, w_enable, refresh, rd_addr, wr_addr,
        q_plus, q_minus, q_valid, done, ovf}, 0);
    @(negedge clk);
    asyn_reset_n = 1'b1;
    @(negedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/digit_select_ctrl.md
DIGIT_SELECT_CTRL -- requirements
Module: digit_select_ctrl

Interface
REQ-001 Parameter UNROLLING, 64, bits per residual chunk.
REQ-002 Parameter ADDR_WIDTH, 7, chunk address width.
REQ-003 Parameter UPPER_WIDTH, 5, integer residual width.
REQ-004 Parameter NUM_CHUNKS, 4, chunks per residual pass, range 2..2**ADDR_WIDTH.
REQ-005 Parameter ONLINE_DELAY, 3, leading iterations whose digit is discarded.
REQ-006 Parameter NUM_DIGITS, 32, quotient digits emitted per operation.
REQ-007 Ports, in this order:
- clk  in  1  clock; all state changes on its rising edge.
- asyn_reset_n  in  1  asynchronous, active-low reset.
- start  in  1  begin an operation; ignored unless idle.
- w_plus_frac, w_minus_frac  in  UNROLLING  residual chunk read back from the residual stage.
- w_plus_int, w_minus_int  in  UPPER_WIDTH  residual integer part.
- w_enable  out  1  enable to the residual stage.
- refresh  out  1  residual-stage carry/store clear.
- rd_addr, wr_addr  out  ADDR_WIDTH  chunk addresses.
- q_plus, q_minus  out  1  borrow-save quotient digit: 10 = +1, 01 = -1, 00 = 0.
- q_valid  out  1  digit available.
- q_ready  in  1  consumer accepts the digit.
- busy  out  1  operation in progress.
- done  out  1  one-cycle pulse after the last digit is accepted.
- ovf  out  1  sticky residual-estimate overflow.

Function
REQ-008 FSM states: IDLE, LOAD, PASS, SELECT, OUT.
REQ-009 IDLE: busy=0; start=1 moves to LOAD and clears the iteration and digit counters.
REQ-010 LOAD lasts one cycle: refresh=1, w_enable=1, rd_addr=wr_addr=0; next state PASS.
REQ-011 PASS lasts NUM_CHUNKS cycles with chunk counter cnt=0..NUM_CHUNKS-1: rd_addr=wr_addr=cnt, w_enable=1, refresh=0.
REQ-012 In the cycle with cnt==1, latch w_plus_frac/w_minus_frac[UNROLLING-1:UNROLLING-2] and w_plus_int/w_minus_int.
REQ-013 After cnt==NUM_CHUNKS-1, the FSM moves to SELECT; cnt wraps to 0.
REQ-014 SELECT lasts one cycle with w_enable=0.
- Estimate E = (int_plus - int_minus) concatenated with (frac2_plus - frac2_minus), as a signed (UPPER_WIDTH+3)-bit value with 2 fractional bits and sign-extended operands.
- Digit: E >= +0.5 gives +1; E < -0.5 gives -1; otherwise 0.
REQ-015 From SELECT, the iteration counter increments.
- If the iteration counter is below ONLINE_DELAY, the digit is discarded and the next state is PASS.
- Otherwise the digit is registered onto q_plus/q_minus and the next state is OUT.
REQ-016 In OUT, q_valid=1 and w_enable=0; q_plus/q_minus are held stable until the transfer (q_valid and q_ready high on the same edge).
REQ-017 On transfer, the digit counter increments.
- If it reaches NUM_DIGITS, the next state is IDLE and done pulses in that first IDLE cycle.
- Otherwise the next state is PASS.
REQ-018 q_ready=1 on entry to OUT gives a transfer on the first OUT edge; no combinational path from q_ready to any output.
REQ-019 start while busy is ignored; start in the done cycle starts a new operation.
REQ-020 rd_addr and wr_addr are 0 in every state other than PASS.

Reset
REQ-021 asyn_reset_n=0 immediately forces IDLE, clears all counters, latched estimate and digit registers, and drives every output to 0, including mid-PASS and during an OUT stall.
REQ-022 After reset deassertion, the block stays in IDLE until start.

Configuration
REQ-023 Macro DIGIT_SEL_OVF_DETECT_EN.
- When defined: ovf is set in SELECT when |E| > 2 and holds until reset or the next LOAD.
- When undefined: ovf is constant 0 and no detection logic exists.

Verification
REQ-024 Reset mid-PASS at cnt=2 -> all outputs 0 asynchronously; start after release -> LOAD with refresh=1.
REQ-025 NUM_CHUNKS=4, int_plus=1, int_minus=0, frac bits 00 held -> every emitted digit is 10; 32 digits; first q_valid at cycle 1+4*(ONLINE_DELAY+1)+ONLINE_DELAY+1 after start; done after the 32nd transfer.
REQ-026 int 0/0, frac_plus=01, frac_minus=00 (E=+0.25) -> digit 00; frac_minus=10 vs plus=00 (E=-0.5) -> digit 00; frac_minus=11 (E=-0.75) -> digit 01.
REQ-027 q_ready held 0 for 10 cycles in OUT -> q_valid and digit stable, w_enable=0, rd_addr=wr_addr=0; transfer on the first edge with q_ready=1.
REQ-028 With DIGIT_SEL_OVF_DETECT_EN, int_plus=3, int_minus=0 -> ovf=1 after SELECT and sticky; without the macro -> ovf=0.
REQ-029 start pulsed while busy -> no effect on counters or addresses.
